// File: rtl/sevseg_scan_decoder.sv
// sevseg_scan_decoder: rebuilds the hex word from multiplexed active-low 7-seg scan lines.
// Define SEVSEG_DP_CAPTURE_EN to also capture decimal points into dp_out.
module sevseg_scan_decoder #(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DIGITS-1:0]   an,
  input  logic [7:0]          ca,
  output logic [4*DIGITS-1:0] data_out,
  output logic [DIGITS-1:0]   dp_out,
  output logic                data_valid,
  output logic                frame_err
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CARM = CW'(STABLE_CYCLES - 2);
`ifdef SEVSEG_DP_CAPTURE_EN
  localparam logic [7:0] CA_MASK = 8'hFF;
`else
  localparam logic [7:0] CA_MASK = 8'h7F;
`endif

  typedef enum logic {SYNC, COLLECT} state_t;

  state_t              state;
  logic [DIGITS-1:0]   an_q, an_p;
  logic [7:0]          ca_q, ca_p;
  logic [CW-1:0]       cnt;
  logic [DIGITS-1:0]   mask;
  logic [4*DIGITS-1:0] shadow;
  logic                done_p, err_p;

  logic [DIGITS-1:0] sel, mask_nx;
  logic [6:0]        seg;
  logic [3:0]        nib;
  logic              seg_ok, same, blank, multi, accept, bad;

  assign sel     = ~an_q;
  assign mask_nx = mask | sel;
  assign same    = ({an_q, ca_q} == {an_p, ca_p});
  assign blank   = (sel == '0);
  assign multi   = !blank && !$onehot(sel);
  // fires only on the cycle the dwell count first reaches its threshold
  assign accept  = same && (cnt == CARM) && !blank;
  assign bad     = multi || !seg_ok;

  always_comb begin
    seg    = ~ca_q[6:0];
    seg_ok = 1'b1;
    nib    = 4'h0;
    case (seg)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: seg_ok = 1'b0;
    endcase
  end

`ifdef SEVSEG_DP_CAPTURE_EN
  logic [DIGITS-1:0] shadow_dp;

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_dp <= '0;
      dp_out    <= '0;
    end else begin
      if (done_p) dp_out <= shadow_dp;
      if (accept && !bad && (state == COLLECT || sel[0])) begin
        for (int i = 0; i < DIGITS; i++)
          if (sel[i]) shadow_dp[i] <= ~ca_q[7];
      end
    end
  end
`else
  assign dp_out = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      an_q       <= '1;
      an_p       <= '1;
      ca_q       <= CA_MASK;
      ca_p       <= CA_MASK;
      cnt        <= '0;
      state      <= SYNC;
      mask       <= '0;
      shadow     <= '0;
      done_p     <= 1'b0;
      err_p      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      an_q       <= an;
      ca_q       <= ca & CA_MASK;
      an_p       <= an_q;
      ca_p       <= ca_q;
      data_valid <= 1'b0;
      frame_err  <= err_p;
      done_p     <= 1'b0;
      err_p      <= 1'b0;
      if (!same)
        cnt <= '0;
      else if (cnt != CMAX)
        cnt <= cnt + 1'b1;
      if (done_p) begin
        data_out   <= shadow;
        data_valid <= 1'b1;
      end
      if (accept) begin
        if (bad) begin
          err_p  <= 1'b1;
          mask   <= '0;
          shadow <= '0;
          state  <= SYNC;
        end else if (state == COLLECT || sel[0]) begin
          for (int i = 0; i < DIGITS; i++)
            if (sel[i]) shadow[4*i +: 4] <= nib;
          if (&mask_nx) begin
            done_p <= 1'b1;
            mask   <= '0;
            state  <= SYNC;
          end else begin
            mask  <= mask_nx;
            state <= COLLECT;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sevseg_scan_decoder.sv
// tb_sevseg_scan_decoder: table vectors, hand sequences and randomized scans
// checked against a dwell-level model of the decoder.
module tb_sevseg_scan_decoder;

  localparam int S = 4;
`ifdef SEVSEG_DP_CAPTURE_EN
  localparam bit         DPEN = 1'b1;
  localparam logic [7:0] CAM  = 8'hFF;
`else
  localparam bit         DPEN = 1'b0;
  localparam logic [7:0] CAM  = 8'h7F;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  an, ca;
  logic [31:0] data_out;
  logic [7:0]  dp_out;
  logic        data_valid, frame_err;

  always #5 clock = ~clock;

  sevseg_scan_decoder #(.DIGITS(8), .STABLE_CYCLES(S)) dut (
    .clock(clock), .reset(reset), .an(an), .ca(ca),
    .data_out(data_out), .dp_out(dp_out),
    .data_valid(data_valid), .frame_err(frame_err)
  );

  logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
    7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int checks = 0, passes = 0;
  int cyc = 0, vcyc = 0, goterr = 0, coll = 0, t7 = 0;
  logic [39:0] gotq[$];
  logic [39:0] expq[$];
  int experr;

  typedef struct {
    logic [7:0] a;
    logic [7:0] c;
    int         n;
  } run_t;
  run_t runs[$];

  typedef struct {
    logic [31:0] w;
    logic [7:0]  dpm;
    int          first;
    int          ndw;
    int          dwell;
    bit          gl;
    int          nv;
    logic [31:0] xd;
    logic [7:0]  xdp;
  } vec_t;
  vec_t tab[8];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (data_valid) begin
        gotq.push_back({dp_out, data_out});
        vcyc <= cyc;
      end
      if (frame_err) goterr <= goterr + 1;
      if (data_valid && frame_err) coll <= coll + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] e);
    checks++;
    if (g === e) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, g, e);
  endtask

  task automatic put(input logic [7:0] a, input logic [7:0] c, input int n);
    int l;
    l = runs.size();
    if (l > 0 && runs[l-1].a == a && runs[l-1].c == (c & CAM))
      runs[l-1].n += n;
    else
      runs.push_back('{a, c & CAM, n});
    an = a;
    ca = c;
    repeat (n) @(negedge clock);
  endtask

  // Dwell-level view: a run of >=S identical samples is one accepted digit.
  function automatic void eval();
    bit         sync;
    logic [7:0] have, d;
    logic [31:0] w;
    sync = 1'b1; have = '0; d = '0; w = '0;
    expq.delete();
    experr = 0;
    foreach (runs[r]) begin
      int low, dig, nb;
      low = 0; dig = 0; nb = -1;
      if (runs[r].n < S) continue;
      for (int i = 0; i < 8; i++)
        if (!runs[r].a[i]) begin low++; dig = i; end
      if (low == 0) continue;
      for (int k = 0; k < 16; k++)
        if (segtab[k] == ~runs[r].c[6:0]) nb = k;
      if (low > 1 || nb < 0) begin
        experr++; sync = 1'b1; have = '0;
        continue;
      end
      if (sync && dig != 0) continue;
      sync = 1'b0;
      w[4*dig +: 4] = nb[3:0];
      d[dig] = ~runs[r].c[7];
      have[dig] = 1'b1;
      if (have == 8'hFF) begin
        expq.push_back({DPEN ? d : 8'h00, w});
        have = '0;
        sync = 1'b1;
      end
    end
  endfunction

  task automatic begin_section();
    an = '1;
    ca = '1;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    runs.delete();
    gotq.delete();
    goterr = 0;
    coll = 0;
    put(8'hFF, 8'hFF, 2);
  endtask

  task automatic end_section(input string nm);
    int m;
    put(8'hFF, 8'hFF, 12);
    eval();
    chk({nm, " nvalid"}, gotq.size(), expq.size());
    m = (gotq.size() < expq.size()) ? gotq.size() : expq.size();
    for (int i = 0; i < m; i++) chk({nm, " word"}, gotq[i], expq[i]);
    chk({nm, " errs"}, goterr, experr);
    chk({nm, " final"}, {dp_out, data_out},
        expq.size() > 0 ? expq[expq.size()-1] : 40'h0);
    chk({nm, " coll"}, coll, 0);
  endtask

  task automatic scan(input logic [31:0] w, input logic [7:0] dpm,
                      input int first, input int ndw, input int dwell, input bit gl);
    for (int k = 0; k < ndw; k++) begin
      int dig;
      dig = (first + k) % 8;
      if (dig == 7) t7 = cyc;
      put(~(8'h01 << dig), {~dpm[dig], ~segtab[w[4*dig +: 4]]}, dwell);
      if (gl) put(8'hFB, 8'h00, 2);
    end
  endtask

  initial begin
    tab[0] = '{32'h12345678, 8'h00, 0, 8, 16, 1'b0, 1, 32'h12345678, 8'h00};
    tab[1] = '{32'h12345678, 8'h00, 0, 8, 16, 1'b1, 1, 32'h12345678, 8'h00};
    tab[2] = '{32'h0000000F, 8'h00, 0, 8, 16, 1'b0, 1, 32'h0000000F, 8'h00};
    tab[3] = '{32'hDEADBEEF, 8'h00, 5, 11, 16, 1'b0, 1, 32'hDEADBEEF, 8'h00};
    tab[4] = '{32'h12345678, 8'h81, 0, 8, 16, 1'b0, 1, 32'h12345678,
               DPEN ? 8'h81 : 8'h00};
    tab[5] = '{32'hCAFEF00D, 8'h00, 0, 16, 6, 1'b0, 2, 32'hCAFEF00D, 8'h00};
    tab[6] = '{32'hA5C3F09B, 8'h00, 0, 8, S, 1'b0, 1, 32'hA5C3F09B, 8'h00};
    tab[7] = '{32'h13579BDF, 8'h00, 0, 8, S-1, 1'b0, 0, 32'h00000000, 8'h00};

    reset = 1'b1;
    an = '1;
    ca = '1;
    repeat (3) @(negedge clock);
    chk("rst data", data_out, 0);
    chk("rst dp", dp_out, 0);
    chk("rst valid", data_valid, 0);
    chk("rst err", frame_err, 0);

    for (int v = 0; v < 8; v++) begin
      begin_section();
      scan(tab[v].w, tab[v].dpm, tab[v].first, tab[v].ndw, tab[v].dwell, tab[v].gl);
      end_section($sformatf("vec%0d", v));
      chk($sformatf("vec%0d nv", v), gotq.size(), tab[v].nv);
      chk($sformatf("vec%0d data", v), data_out, tab[v].xd);
      chk($sformatf("vec%0d dp", v), dp_out, tab[v].xdp);
      chk($sformatf("vec%0d noerr", v), goterr, 0);
      if (v == 0) chk("latency", vcyc - t7, 1 + S + 1);
    end

    // two anodes low mid-frame
    begin_section();
    scan(32'h12345678, 8'h00, 0, 8, 16, 1'b0);
    scan(32'hDEADBEEF, 8'h00, 0, 3, 16, 1'b0);
    put(8'hFC, {1'b1, ~segtab[0]}, 16);
    put(8'hFF, 8'hFF, 8);
    chk("multi err", goterr, 1);
    chk("multi hold", data_out, 32'h12345678);
    chk("multi nv", gotq.size(), 1);
    scan(32'hDEADBEEF, 8'h00, 0, 8, 16, 1'b0);
    end_section("multi");
    chk("multi next", data_out, 32'hDEADBEEF);

    // blank segments on a selected digit, then scan starting mid-way
    begin_section();
    scan(32'h12345678, 8'h00, 0, 3, 16, 1'b0);
    put(8'hF7, 8'hFF, 16);
    put(8'hFF, 8'hFF, 8);
    chk("badseg err", goterr, 1);
    chk("badseg nv", gotq.size(), 0);
    scan(32'h0BADC0DE, 8'h00, 5, 11, 16, 1'b0);
    end_section("badseg");
    chk("badseg next", data_out, 32'h0BADC0DE);

    // reset mid-frame
    begin_section();
    scan(32'h87654321, 8'h00, 0, 5, 16, 1'b0);
    an = '1;
    ca = '1;
    reset = 1'b1;
    @(negedge clock);
    chk("midrst data", data_out, 0);
    chk("midrst valid", data_valid, 0);
    chk("midrst err", frame_err, 0);
    chk("midrst nv", gotq.size(), 0);
    reset = 1'b0;
    runs.delete();
    gotq.delete();
    goterr = 0;
    put(8'hFF, 8'hFF, 2);
    scan(32'h0000000F, 8'h00, 0, 8, 16, 1'b0);
    end_section("midrst");
    chk("midrst next", data_out, 32'h0000000F);

    // randomized scans with glitches, jumps and bad dwells
    for (int sct = 0; sct < 20; sct++) begin
      int nd, dcur;
      begin_section();
      nd = $urandom_range(20, 50);
      dcur = 0;
      for (int k = 0; k < nd; k++) begin
        int r, x, y, len;
        logic [7:0] a, c;
        logic b;
        r = $urandom_range(0, 99);
        if (r < 3) begin
          x = $urandom_range(0, 7);
          y = (x + 1 + $urandom_range(0, 6)) % 8;
          a = ~((8'h01 << x) | (8'h01 << y));
        end else if (r < 8) begin
          a = ~(8'h01 << $urandom_range(0, 7));
        end else begin
          a = ~(8'h01 << dcur);
          dcur = (dcur + 1) % 8;
        end
        b = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 99) < 3) c = 8'($urandom);
        else c = {b, ~segtab[$urandom_range(0, 15)]};
        if ($urandom_range(0, 99) < 10) len = $urandom_range(1, S - 1);
        else len = $urandom_range(S, 12);
        put(a, c, len);
        if ($urandom_range(0, 99) < 10) put(8'hFF, 8'hFF, $urandom_range(1, 3));
      end
      end_section($sformatf("rand%0d", sct));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
